masked_logic_hpc2_vec: RTL and testbench

- Vectorised, pipelined HPC2 masked two-input Boolean gate for the masked datapath.
- Processes WIDTH independent lanes of (D+1)-share Boolean-masked bits per transaction.
- The operation is selectable per transaction: AND, NAND, OR or NOR.
- Adds valid tracking, input-qualified register capture and a completed-operation counter, so it can sit directly in streaming S-box pipelines in place of per-bit gadget instances.

---
 rtl/masked_logic_hpc2_vec.sv | 118 +++++++++++
 tb/tb_masked_logic_hpc2_vec.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/masked_logic_hpc2_vec.sv
`default_nettype none
// ============================================================================
// Module   : masked_logic_hpc2_vec
// Brief    : WIDTH-lane, (D+1)-share HPC2 masked AND/NAND/OR/NOR gate with a
//            fixed 2-cycle latency, valid tracking and a saturating op counter.
// Revision : 1.0 - initial release
// ============================================================================
module masked_logic_hpc2_vec #(
  parameter int D     = 1,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [1:0]                      op,
  input  logic [WIDTH*(D+1)-1:0]          a,
  input  logic [WIDTH*(D+1)-1:0]          b,
  input  logic [WIDTH*(D*(D+1)/2)-1:0]    r,
  output logic                            out_valid,
  output logic [WIDTH*(D+1)-1:0]          c,
  output logic [CNT_W-1:0]                op_count
);

  localparam int SH  = D + 1;
  localparam int RND = D * (D + 1) / 2;

  logic             r_vld1;
  logic             r_vld2;
  logic [1:0]       r_op1;
  logic [CNT_W-1:0] r_cnt;
  logic             w_flip;

  // OR/NOR run as an AND on complemented operands (De Morgan); NAND and OR
  // need the recombined result complemented, done on share 0 only.
  assign w_flip = r_op1[0] ^ r_op1[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld1 <= 1'b0;
      r_vld2 <= 1'b0;
      r_op1  <= 2'b00;
      r_cnt  <= '0;
    end else begin
      r_vld1 <= in_valid;
      r_vld2 <= r_vld1;
      if (in_valid) begin
        r_op1 <= op;
      end
      if (r_vld1 && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out_valid = r_vld2;
  assign op_count  = r_cnt;

  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    logic [SH-1:0]    w_ap;
    logic [SH-1:0]    w_bp;
    logic [SH*SH-1:0] w_u;
    logic [SH*SH-1:0] w_v;
    logic [SH-1:0]    w_c;
    logic [SH-1:0]    r_a;
    logic [SH-1:0]    r_w;
    logic [SH*SH-1:0] r_u;
    logic [SH*SH-1:0] r_v;
    logic [SH-1:0]    r_c;

    assign w_ap = a[l*SH +: SH] ^ {{(SH-1){1'b0}}, op[1]};
    assign w_bp = b[l*SH +: SH] ^ {{(SH-1){1'b0}}, op[1]};

    for (genvar i = 0; i < SH; i++) begin : g_share
      for (genvar j = 0; j < SH; j++) begin : g_peer
        if (i != j) begin : g_cross
          localparam int LO = (i < j) ? i : j;
          localparam int HI = (i < j) ? j : i;
          localparam int K  = LO * D - (LO * (LO - 1)) / 2 + (HI - LO - 1);
          assign w_u[i*SH+j] = ~w_ap[i] & r[l*RND+K];
          assign w_v[i*SH+j] = w_bp[j] ^ r[l*RND+K];
        end else begin : g_self
          assign w_u[i*SH+j] = 1'b0;
          assign w_v[i*SH+j] = 1'b0;
        end
      end

      // Diagonal U/V terms are tied to zero, so XOR-ing the whole row is safe.
      assign w_c[i] = r_w[i] ^ (^(r_u[i*SH +: SH] ^ (r_v[i*SH +: SH] & {SH{r_a[i]}})));
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_a <= '0;
        r_w <= '0;
        r_u <= '0;
        r_v <= '0;
      end else if (in_valid) begin
        r_a <= w_ap;
        r_w <= w_ap & w_bp;
        r_u <= w_u;
        r_v <= w_v;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_c <= '0;
      end else if (r_vld1) begin
        r_c <= w_c ^ {{(SH-1){1'b0}}, w_flip};
      end
    end

    assign c[l*SH +: SH] = r_c;
  end

endmodule
`default_nettype wire

// File: tb/tb_masked_logic_hpc2_vec.sv
`default_nettype none
// ============================================================================
// Module   : tb_masked_logic_hpc2_vec
// Brief    : Directed self-checking bench for masked_logic_hpc2_vec.
// Revision : 1.0 - initial release
// ============================================================================
module tb_masked_logic_hpc2_vec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid2, in_valid3;
  logic [1:0]  op, op2;
  logic [15:0] a, b;
  logic [7:0]  r;
  logic        out_valid, out_valid2, out_valid3;
  logic [15:0] c, c3;
  logic [15:0] op_count, op_count2;
  logic [3:0]  op_count3;
  logic [11:0] a2, b2, r2, c2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  masked_logic_hpc2_vec #(.D(1), .WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .a(a), .b(b), .r(r),
    .out_valid(out_valid), .c(c), .op_count(op_count));

  masked_logic_hpc2_vec #(.D(2), .WIDTH(4), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .op(op2), .a(a2), .b(b2), .r(r2),
    .out_valid(out_valid2), .c(c2), .op_count(op_count2));

  masked_logic_hpc2_vec #(.D(1), .WIDTH(8), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .op(op), .a(a), .b(b), .r(r),
    .out_valid(out_valid3), .c(c3), .op_count(op_count3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mask1(input logic [7:0] x);
    logic [15:0] m;
    logic s;
    for (int l = 0; l < 8; l++) begin
      s = 1'($urandom);
      m[2*l]   = s;
      m[2*l+1] = x[l] ^ s;
    end
    return m;
  endfunction

  function automatic logic [7:0] unmask1(input logic [15:0] v);
    logic [7:0] u;
    for (int l = 0; l < 8; l++) u[l] = v[2*l] ^ v[2*l+1];
    return u;
  endfunction

  function automatic logic [11:0] pack3(input logic [3:0] x, input logic [3:0] s0, input logic [3:0] s1);
    logic [11:0] m;
    for (int l = 0; l < 4; l++) begin
      m[3*l]   = s0[l];
      m[3*l+1] = s1[l];
      m[3*l+2] = x[l] ^ s0[l] ^ s1[l];
    end
    return m;
  endfunction

  function automatic logic [3:0] unmask2(input logic [11:0] v);
    logic [3:0] u;
    for (int l = 0; l < 4; l++) u[l] = v[3*l] ^ v[3*l+1] ^ v[3*l+2];
    return u;
  endfunction

  // Functional table: op, x, y, hand-computed op(x, y)
  logic [1:0] t_op [8];
  logic [7:0] t_x  [8];
  logic [7:0] t_y  [8];
  logic [7:0] t_e  [8];
  // Bubble sequence, one entry per cycle
  logic       p_v  [7];
  logic       p_ov [7];
  logic [1:0] p_op [7];
  logic [7:0] p_c  [7];

  initial begin
    t_op = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    t_x  = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    t_y  = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'hCC, 8'hCC, 8'hCC, 8'hCC};
    t_e  = '{8'h30, 8'hCF, 8'hFC, 8'h03, 8'h88, 8'h77, 8'hEE, 8'h11};
    p_v  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    p_ov = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    p_op = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd1};
    p_c  = '{8'h00, 8'h00, 8'h30, 8'h30, 8'hFC, 8'h03, 8'h03};

    rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; in_valid3 = 1'b0;
    op = 2'd0; op2 = 2'd0; a = '0; b = '0; r = '0; a2 = '0; b2 = '0; r2 = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset then idle
    check_eq("rst_cnt2", op_count2, 0);
    check_eq("rst_c2", c2, 0);
    check_eq("rst_cnt3", op_count3, 0);
    for (int n = 0; n < 10; n++) begin
      check_eq("idle_vld", out_valid, 0);
      check_eq("idle_c", c, 0);
      check_eq("idle_cnt", op_count, 0);
      tick();
    end

    // Back-to-back functional vectors, all four ops
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        op = t_op[k]; a = mask1(t_x[k]); b = mask1(t_y[k]); r = 8'($urandom); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k >= 1) begin
        check_eq("func_vld", out_valid, 1);
        check_eq("func_c", unmask1(c), t_e[k-1]);
      end
    end
    check_eq("func_cnt", op_count, 8);

    // Randomness sweep on the D=2 instance: x=0xA, y=0x6
    a2 = pack3(4'hA, 4'h3, 4'h9);
    b2 = pack3(4'h6, 4'hC, 4'h5);
    for (int k = 0; k <= 8192; k++) begin
      if (k < 8192) begin
        op2 = (k % 2 == 1) ? 2'b10 : 2'b00; r2 = 12'(k >> 1); in_valid2 = 1'b1;
      end else begin
        in_valid2 = 1'b0;
      end
      tick();
      if (k >= 1) begin
        check_eq("rnd_vld", out_valid2, 1);
        check_eq("rnd_c", unmask2(c2), ((k - 1) % 2 == 1) ? 4'hE : 4'h2);
      end
    end

    // Bubbles and hold; idle cycles carry garbage that must not be captured
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 7; n++) begin
      check_eq("bub_vld", out_valid, p_ov[n]);
      check_eq("bub_c", unmask1(c), p_c[n]);
      in_valid = p_v[n];
      op = p_op[n];
      a = mask1(p_v[n] ? 8'hF0 : 8'h55);
      b = mask1(p_v[n] ? 8'h3C : 8'h0F);
      r = 8'($urandom);
      tick();
    end
    check_eq("bub_cnt", op_count, 3);

    // Reset mid-flight, with in_valid held high during reset
    op = 2'd0; a = mask1(8'hF0); b = mask1(8'h3C); r = 8'($urandom); in_valid = 1'b1;
    tick();
    rst = 1'b1; op = 2'd3; a = mask1(8'h12); b = mask1(8'h34);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      check_eq("mid_vld", out_valid, 0);
      check_eq("mid_cnt", op_count, 0);
      check_eq("mid_c", c, 0);
      tick();
    end
    op = 2'd2; a = mask1(8'hAA); b = mask1(8'hCC); r = 8'($urandom); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("mid_new_vld0", out_valid, 0);
    tick();
    check_eq("mid_new_vld", out_valid, 1);
    check_eq("mid_new_c", unmask1(c), 8'hEE);
    check_eq("mid_new_cnt", op_count, 1);

    // Saturation on the CNT_W=4 instance
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 24; n++) begin
      int done;
      done = (n >= 2) ? ((n - 1 > 20) ? 20 : n - 1) : 0;
      check_eq("sat_cnt", op_count3, (done > 15) ? 15 : done);
      check_eq("sat_vld", out_valid3, (n >= 2 && n <= 21) ? 1 : 0);
      in_valid3 = (n < 20);
      a = mask1(8'($urandom)); b = mask1(8'($urandom)); r = 8'($urandom);
      tick();
    end
    check_eq("sat_final", op_count3, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
